irq_pending_arbiter: RTL and testbench

Captures rising edges on 8 request lines into a pending register and serves them one at a time, highest index first. Each grant is presented as a registered 3-bit index with a valid/ready handshake. The served pending bit is cleared on acceptance. The block sits in front of the 8-to-3 priority encode path and turns raw level requests into a sequenced, back-pressurable event stream for a downstream handler.

---
 rtl/irq_pending_arbiter_pkg.sv | 19 +
 rtl/irq_pending_arbiter_if.sv | 21 ++
 rtl/irq_pending_arbiter_prio.sv | 16 +
 rtl/irq_pending_arbiter.sv | 67 ++++++
 tb/tb_irq_pending_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/irq_pending_arbiter_pkg.sv
// Shared types and helpers for the pending-interrupt arbiter.
package irq_arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Grant handshake bundle: registered index with valid/ready.
interface irq_pending_arbiter_if;
    import irq_arb_pkg::*;

    logic            out_valid;
    logic [IDXW-1:0] out_idx;
    logic            out_ready;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/irq_pending_arbiter_prio.sv
// Combinational 8-to-3 priority encoder, highest set index wins.
module priority_encoder_8_3 (
    input  logic [7:0] in_vec,
    output logic [2:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 3'd0;
        valid = |in_vec;
        for (int i = 0; i < 8; i++) begin
            if (in_vec[i]) idx = i[2:0];
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Latches request rising edges into pending and serves them highest index first.
module irq_pending_arbiter
    import irq_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          mask,
    irq_pending_arbiter_if.master grant,
    output logic [N-1:0]          pending,
    output logic                  overflow,
    output logic                  any_pending
);

    logic [N-1:0]    req_q;
    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    sel_in;
    logic [IDXW-1:0] sel_idx;
    logic            sel_valid;
    logic            hs;
    state_t          state;

    assign rise        = req & ~req_q;
    assign hs          = grant.out_valid & grant.out_ready;
    assign clr         = hs ? onehot(grant.out_idx) : '0;
    assign sel_in      = pending & mask;
    assign any_pending = |sel_in;

    priority_encoder_8_3 u_prio (
        .in_vec (sel_in),
        .idx    (sel_idx),
        .valid  (sel_valid)
    );

    // A rise on the bit being cleared wins, so the new event is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q           <= '0;
            pending         <= '0;
            overflow        <= 1'b0;
            state           <= IDLE;
            grant.out_valid <= 1'b0;
            grant.out_idx   <= '0;
        end else begin
            req_q    <= req;
            pending  <= (pending & ~clr) | rise;
            overflow <= |(rise & pending & ~clr);
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant.out_idx   <= sel_idx;
                        grant.out_valid <= 1'b1;
                        state           <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (grant.out_ready) begin
                        grant.out_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Randomized and directed bench for irq_pending_arbiter with a grant scoreboard.
module tb_irq_pending_arbiter;
    import irq_arb_pkg::*;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] req  = 8'h00;
    logic [7:0] mask = 8'hFF;
    logic [7:0] pending;
    logic       overflow;
    logic       any_pending;

    irq_pending_arbiter_if gnt();

    irq_pending_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .grant       (gnt),
        .pending     (pending),
        .overflow    (overflow),
        .any_pending (any_pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // Reference state: per-line event flags and the grant currently offered.
    bit m_pend[8];
    bit m_seen[8];
    bit m_valid = 1'b0;
    bit m_ovf   = 1'b0;
    int m_idx   = 0;

    function automatic logic [7:0] pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 1'b0;
            m_seen[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_idx   = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit np[8];
        bit ov;
        bit served;
        int cleared;
        int best;
        ov      = 1'b0;
        best    = -1;
        served  = m_valid && gnt.out_ready;
        cleared = served ? m_idx : -1;
        for (int i = 0; i < 8; i++) begin
            bit event_now;
            event_now = req[i] && !m_seen[i];
            np[i] = (m_pend[i] && i != cleared) || event_now;
            if (event_now && m_pend[i] && i != cleared) ov = 1'b1;
        end
        for (int i = 7; i >= 0; i--) begin
            if (best < 0 && m_pend[i] && mask[i]) best = i;
        end
        if (m_valid) begin
            if (gnt.out_ready) m_valid = 1'b0;
        end else if (best >= 0) begin
            m_valid = 1'b1;
            m_idx   = best;
            exp_q.push_back(best);
        end
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = np[i];
            m_seen[i] = req[i];
        end
        m_ovf = ov;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_clear();
        else model_step();
    end

    // Monitor: per-cycle state compare plus grant pop on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(gnt.out_valid), 32'(m_valid));
            chk("pending", 32'(pending), 32'(pend_vec()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("any_pending", 32'(any_pending), 32'(|(pend_vec() & mask)));
            if (gnt.out_valid && gnt.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_idx: got %0d expected none at %0t",
                             gnt.out_idx, $time);
                end else begin
                    chk("grant_idx", 32'(gnt.out_idx), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive(input logic [7:0] r, input logic [7:0] m,
                         input logic rdy, input int n);
        req           = r;
        mask          = m;
        gnt.out_ready = rdy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] nr;
        gnt.out_ready = 1'b0;
        #12;
        rst = 1'b0;
        drive(8'h00, 8'hFF, 1'b1, 2);
        // single event on line 5
        drive(8'h20, 8'hFF, 1'b1, 4);
        drive(8'h00, 8'hFF, 1'b1, 2);
        // simultaneous events on 2 and 6
        drive(8'h44, 8'hFF, 1'b1, 6);
        drive(8'h00, 8'hFF, 1'b1, 2);
        // hold index 3 while 7 arrives
        drive(8'h08, 8'hFF, 1'b0, 3);
        drive(8'h88, 8'hFF, 1'b0, 5);
        drive(8'h00, 8'hFF, 1'b1, 6);
        // overflow on 4, then rise coinciding with its handshake
        drive(8'h10, 8'hFF, 1'b0, 3);
        drive(8'h00, 8'hFF, 1'b0, 1);
        drive(8'h10, 8'hFF, 1'b0, 2);
        drive(8'h00, 8'hFF, 1'b0, 1);
        drive(8'h10, 8'hFF, 1'b1, 5);
        drive(8'h00, 8'hFF, 1'b1, 3);
        // masked event on 7, later unmasked
        drive(8'h80, 8'h0F, 1'b1, 3);
        drive(8'h00, 8'h0F, 1'b1, 2);
        drive(8'h00, 8'h8F, 1'b1, 4);
        // reset during an offered grant, request held high
        drive(8'h02, 8'hFF, 1'b0, 3);
        chk("pre_rst_valid", 32'(gnt.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(gnt.out_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(8'h02, 8'hFF, 1'b1, 5);
        drive(8'h00, 8'hFF, 1'b1, 2);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            nr = req;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(3) == 0) nr[i] = ~nr[i];
            end
            drive(nr, ($urandom_range(15) == 0) ? 8'($urandom) : mask,
                  1'($urandom_range(2) != 0), 1);
        end
        drive(8'h00, 8'hFF, 1'b1, 20);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
